// File: rtl/guineveer_uart_pkg.sv
// rtl/guineveer_uart_pkg.sv - shared types and defaults for the UART receiver
package guineveer_uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 289;

endpackage

// File: rtl/guineveer_sync_2ff.sv
// rtl/guineveer_sync_2ff.sv - two-flop synchronizer with configurable reset value
module guineveer_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/guineveer_uart_rx.sv
// rtl/guineveer_uart_rx.sv - 8N1 oversampling UART receiver with valid/ready output
module guineveer_uart_rx
    import guineveer_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    uart_rx_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     sh_q, sh_d;
    logic           commit_d;
    logic           ferr_d;

    logic           rx_s;
    logic           rx_q;

    logic [7:0]     data_q;
    logic           valid_q;
    logic           ferr_q;
    logic           overrun_q;
    logic           busy_q;

    guineveer_sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d     (rx_i),
        .q     (rx_s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            rx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_s;
            // Registered decode of the next state keeps busy_o free of decode glitches.
            busy_q  <= (state_d == START) || (state_d == DATA) || (state_d == STOP);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        commit_d = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            IDLE: begin
                if (rx_q && !rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    cnt_d = CNT_FULL;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    // Leaving mid-stop-bit lets the next start edge be caught back-to-back.
                    if (rx_s) begin
                        commit_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_d   = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ferr_q    <= ferr_d;
            overrun_q <= 1'b0;
            if (commit_d) begin
                if (!valid_q || ready_i) begin
                    data_q  <= sh_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_guineveer_uart_rx.sv
// tb/tb_guineveer_uart_rx.sv - directed self-checking bench for guineveer_uart_rx
module tb_guineveer_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_ni;
    logic       rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] beats[$];
    logic       beat_busy[$];
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int busy_cnt = 0;

    guineveer_uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rx_i       (rx),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (valid_o && ready) begin
                beats.push_back(data_o);
                beat_busy.push_back(busy_o);
            end
            if (frame_err_o) ferr_cnt++;
            if (overrun_o)   ovr_cnt++;
            if (busy_o)      busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int clocks);
        rx = b;
        tick(clocks);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
        send_bit(1'b1, CPB);
    endtask

    initial begin
        int b0;
        int f0;
        int o0;
        int bz0;
        int d;

        rst_ni = 1'b0;
        rx     = 1'b1;
        ready  = 1'b1;

        @(negedge clk);
        check("reset_data",  32'(data_o),      32'h0);
        check("reset_valid", 32'(valid_o),     32'h0);
        check("reset_ferr",  32'(frame_err_o), 32'h0);
        check("reset_ovr",   32'(overrun_o),   32'h0);
        check("reset_busy",  32'(busy_o),      32'h0);
        tick(2);
        rst_ni = 1'b1;
        tick(5);

        // Single byte
        b0 = beats.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_byte(8'h55);
        tick(20);
        @(negedge clk);
        check("b55_count", 32'(beats.size() - b0), 32'd1);
        check("b55_data",  32'(beats[b0]),         32'h55);
        check("b55_ferr",  32'(ferr_cnt - f0),     32'd0);
        check("b55_ovr",   32'(ovr_cnt - o0),      32'd0);
        check("b55_valid_consumed", 32'(valid_o),  32'h0);

        // Back-to-back frames
        tick(1);
        b0 = beats.size();
        send_byte(8'hA5);
        send_byte(8'h3C);
        tick(20);
        @(negedge clk);
        check("b2b_count",  32'(beats.size() - b0), 32'd2);
        check("b2b_first",  32'(beats[b0]),         32'hA5);
        check("b2b_second", 32'(beats[b0 + 1]),     32'h3C);
        check("b2b_busy_gap", 32'(beat_busy[b0]),   32'h0);

        // Short low glitch is rejected by the mid-start-bit check
        tick(1);
        b0 = beats.size(); bz0 = busy_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        @(negedge clk);
        d = busy_cnt - bz0;
        check("glitch_no_beat",  32'(beats.size() - b0), 32'd0);
        check("glitch_busy_seen", 32'(d > 0), 32'd1);
        check("glitch_busy_short", 32'(d <= CPB / 2), 32'd1);
        check("glitch_busy_idle", 32'(busy_o), 32'h0);

        // Framing error with stop bit held low
        tick(1);
        b0 = beats.size(); f0 = ferr_cnt;
        for (int i = 0; i < 9; i++) send_bit(1'b0, CPB);
        send_bit(1'b0, 40);
        @(negedge clk);
        check("ferr_pulse",   32'(ferr_cnt - f0),      32'd1);
        check("ferr_no_beat", 32'(beats.size() - b0),  32'd0);
        check("ferr_wait_idle_busy", 32'(busy_o),      32'h0);
        tick(1);
        rx = 1'b1;
        tick(5);
        send_byte(8'h7E);
        tick(20);
        @(negedge clk);
        check("ferr_recover_count", 32'(beats.size() - b0), 32'd1);
        check("ferr_recover_data",  32'(beats[b0]),         32'h7E);

        // Overrun while the holding register is full
        tick(1);
        ready = 1'b0;
        b0 = beats.size(); o0 = ovr_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        tick(20);
        @(negedge clk);
        check("ovr_data_held", 32'(data_o),             32'h11);
        check("ovr_valid",     32'(valid_o),            32'h1);
        check("ovr_pulse",     32'(ovr_cnt - o0),       32'd1);
        check("ovr_no_beat",   32'(beats.size() - b0),  32'd0);
        tick(1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        @(negedge clk);
        check("ovr_drain_valid", 32'(valid_o),           32'h0);
        check("ovr_drain_count", 32'(beats.size() - b0), 32'd1);
        check("ovr_drain_data",  32'(beats[b0]),         32'h11);

        // Asynchronous reset during data bit 3 with a held byte pending
        tick(1);
        send_byte(8'h5A);
        tick(20);
        @(negedge clk);
        check("rst_pre_valid", 32'(valid_o), 32'h1);
        check("rst_pre_data",  32'(data_o),  32'h5A);
        tick(1);
        send_bit(1'b0, CPB);
        send_bit(1'b0, 3 * CPB);
        send_bit(1'b0, CPB / 2);
        check("rst_pre_busy", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("rst_async_data",  32'(data_o),      32'h0);
        check("rst_async_valid", 32'(valid_o),     32'h0);
        check("rst_async_busy",  32'(busy_o),      32'h0);
        check("rst_async_ferr",  32'(frame_err_o), 32'h0);
        check("rst_async_ovr",   32'(overrun_o),   32'h0);
        rx = 1'b1;
        tick(3);
        rst_ni = 1'b1;
        ready  = 1'b1;
        tick(5);
        b0 = beats.size();
        send_byte(8'hC3);
        tick(20);
        @(negedge clk);
        check("rst_recover_count", 32'(beats.size() - b0), 32'd1);
        check("rst_recover_data",  32'(beats[b0]),         32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
